// File: rtl/truth_table_checker_pkg.sv
// ============================================================================
// Module      : truth_table_checker_pkg
// Description : Shared state encoding and reference truth tables for the
//               exhaustive truth-table checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package truth_table_checker_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Two-input reference tables; bit i is the required output for minterm i
  localparam logic [3:0] NXOR_TT = 4'b1001;
  localparam logic [3:0] XOR_TT  = 4'b0110;

endpackage

`default_nettype wire

// File: rtl/settle_timer.sv
// ============================================================================
// Module      : settle_timer
// Description : Settle-time counter with clear/enable; terminal flags the
//               last settle cycle (count == SETTLE-1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  // Four bits cover the full 1..15 settle range
  localparam int CW = 4;

  logic [CW-1:0] count;

  // Clear has priority so a new minterm always starts its settle window at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = (count == CW'(SETTLE - 1));

endmodule

`default_nettype wire

// File: rtl/truth_table_checker.sv
// ============================================================================
// Module      : truth_table_checker
// Description : Drives every minterm of an N-input combinational DUT, waits
//               SETTLE cycles, samples dut_y against EXPECTED and reports the
//               mismatch count and the lowest failing minterm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int                N        = 2,
  parameter logic [2**N-1:0]   EXPECTED = NXOR_TT,
  parameter int                SETTLE   = 1
) (
  input  logic         CLK,
  input  logic         n_RESET,
  input  logic         start,
  input  logic         dut_y,
  output logic [N-1:0] mt,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   fail_count,
  output logic [N-1:0] first_fail
);

  localparam logic [N-1:0] MT_LAST = '1;

  state_t state;
  logic   start_accept;
  logic   timer_clear;
  logic   timer_en;
  logic   timer_done;

  // start is only honoured when no sweep is in flight
  assign start_accept = start && ((state == IDLE) || (state == DONE));
  // Counter restarts for every minterm; it stops once the terminal count is reached
  assign timer_clear  = start_accept || (state == SAMPLE);
  assign timer_en     = (state == APPLY) && !timer_done;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk      (CLK),
    .rst_n    (n_RESET),
    .clear    (timer_clear),
    .enable   (timer_en),
    .terminal (timer_done)
  );

  // Sweep controller: mt only moves on the SAMPLE->APPLY edge so it is stable for the whole settle window
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      state      <= IDLE;
      mt         <= '0;
      fail_count <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= APPLY;
            mt         <= '0;
            fail_count <= '0;
            first_fail <= '0;
          end
        end
        APPLY: begin
          if (timer_done) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          // Case inequality so an X/Z response is scored as a mismatch
          if (dut_y !== EXPECTED[mt]) begin
            fail_count <= fail_count + (N+1)'(1);
            if (fail_count == '0) begin
              first_fail <= mt;
            end
          end
          if (mt == MT_LAST) begin
            state <= DONE;
          end else begin
            mt    <= mt + N'(1);
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags decode registered state only; dut_y never reaches an output combinationally
  assign busy = (state == APPLY) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && (fail_count == '0);

endmodule

`default_nettype wire
